alu_result_display_scan: RTL

- Downstream display stage for the 8-bit ALU result bus.
- Accepts an 8-bit unsigned result through a valid/ready handshake.
- Converts the result to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the digits across the three lowest anodes of the 8-digit display board; the cathode encoding matches the existing single-digit display path.

---
 rtl/alu_result_display_scan_if.sv | 9 +
 rtl/alu_result_display_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_result_display_scan_if.sv
// Valid/ready load channel carrying an 8-bit ALU result into the display stage.
interface alu_result_display_scan_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/alu_result_display_scan.sv
// Binary-to-BCD (double-dabble) conversion of an 8-bit result, shown on a
// 3-digit time-multiplexed 7-segment scan with optional leading-zero blanking.
module alu_result_display_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LEAD  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_result_display_scan_if.slave  bus,
    output logic                      done,
    output logic [6:0]                s,
    output logic [7:0]                AN
);

    localparam int unsigned     PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_bin;
    logic [11:0]   r_bcd, w_bcd_adj;
    logic [2:0]    r_iter;
    logic [3:0]    r_hund, r_tens, r_ones;
    logic          r_done;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic          w_load;
    logic [3:0]    w_digit;
    logic          w_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        bus.in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load = 1'b1;
                    w_next = S_CONVERT;
                end
            end
            S_CONVERT: if (r_iter == 3'd7) w_next = S_UPDATE;
            S_UPDATE:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Add-3 correction is applied before the shift within the same cycle.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_hund <= '0;
            r_tens <= '0;
            r_ones <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_UPDATE);
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_bin  <= bus.in_data;
                        r_bcd  <= '0;
                        r_iter <= '0;
                    end
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
                    r_iter         <= r_iter + 3'd1;
                end
                S_UPDATE: begin
                    r_hund <= r_bcd[11:8];
                    r_tens <= r_bcd[7:4];
                    r_ones <= r_bcd[3:0];
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        w_digit = r_ones;
        w_blank = 1'b0;
        AN      = 8'hFF;
        case (r_idx)
            2'd0: begin
                AN      = 8'b11111110;
                w_digit = r_ones;
            end
            2'd1: begin
                AN      = 8'b11111101;
                w_digit = r_tens;
                w_blank = BLANK_LEAD && (r_hund == 4'd0) && (r_tens == 4'd0);
            end
            2'd2: begin
                AN      = 8'b11111011;
                w_digit = r_hund;
                w_blank = BLANK_LEAD && (r_hund == 4'd0);
            end
            default: w_blank = 1'b1;
        endcase
        s = w_blank ? 7'b1111111 : ~seg7(w_digit);
    end

endmodule
